// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory bus arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_MAX_STREAK = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } state_e;

    typedef enum logic {
        OwnI,
        OwnD
    } owner_e;

    // Which requester owns the bus while a transaction is outstanding.
    function automatic owner_e owner_of(state_e s);
        if (s == StBusyD) begin
            return OwnD;
        end
        return OwnI;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision for the shared memory bus: data wins unless fetch has waited
// through MAX_STREAK consecutive data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                starve;

    always_comb begin
        starve   = i_req && (streak_q == STREAK_MAX);
        d_gnt    = idle && d_req && !starve;
        i_gnt    = idle && i_req && !d_gnt;
        streak_d = streak_q;
        if (d_gnt) begin
            // Streak only grows while fetch is actually being passed over.
            if (!i_req) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (i_gnt) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Non-pipelined arbiter sharing one memory bus between CPU fetch and load/store
// ports; one transaction outstanding at a time, completion signalled by m_ack.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata
);

    state_e state_q, state_d;
    owner_e owner;
    logic   idle;
    logic   ack_done;

    assign idle     = (state_q == StIdle);
    assign owner    = owner_of(state_q);
    assign ack_done = m_ack && !idle;
    // Derived from the state register so reset drops it without waiting for a clock.
    assign m_req    = !idle;

    mem_arb_select #(
        .MAX_STREAK(MAX_STREAK)
    ) u_select (
        .clk  (clk),
        .rst  (rst),
        .idle (idle),
        .i_req(i_req),
        .d_req(d_req),
        .i_gnt(i_gnt),
        .d_gnt(d_gnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (d_gnt) begin
                    state_d = StBusyD;
                end else if (i_gnt) begin
                    state_d = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (m_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
        end else if (d_gnt) begin
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
        end else if (i_gnt) begin
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= ack_done && (owner == OwnI);
            d_rvalid <= ack_done && (owner == OwnD);
            if (ack_done && (owner == OwnI)) begin
                i_rdata <= m_rdata;
            end
            if (ack_done && (owner == OwnD)) begin
                d_rdata <= m_we ? '0 : m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with default parameters.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;

    int n_cmp;
    int n_err;

    mem_bus_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_be    (m_be),
        .m_ack   (m_ack),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; m_ack = 1'b0; m_rdata = '0;
        #12;
        n_cmp++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we});
        end
        n_cmp++;
        if ({i_rdata, d_rdata, m_addr, m_wdata, m_be} !== 132'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0",
                     {i_rdata, d_rdata, m_addr, m_wdata, m_be});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        cyc(); i_req = 1'b1; i_addr = 32'h100; #1;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            n_err++; $display("FAIL fetch_gnt: got %b expected 10", {i_gnt, d_gnt});
        end
        cyc(); i_req = 1'b0; i_addr = 32'h999; #1;
        n_cmp++;
        if ({m_req, m_we, m_be, m_addr, i_gnt} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_bus_c1: got req=%b we=%b be=%h addr=%h gnt=%b expected 1 0 f 100 0",
                     m_req, m_we, m_be, m_addr, i_gnt);
        end
        cyc(); m_ack = 1'b1; m_rdata = 32'hDEADBEEF; #1;
        n_cmp++;
        if ({m_req, m_addr, i_rvalid} !== {1'b1, 32'h100, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_bus_c2: got req=%b addr=%h rvalid=%b expected 1 100 0",
                     m_req, m_addr, i_rvalid);
        end
        cyc(); m_ack = 1'b0; m_rdata = '0; #1;
        n_cmp++;
        if ({i_rvalid, i_rdata, d_rvalid, m_req} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_resp: got iv=%b id=%h dv=%b mreq=%b expected 1 deadbeef 0 0",
                     i_rvalid, i_rdata, d_rvalid, m_req);
        end
        cyc(); #1;
        n_cmp++;
        if ({i_rvalid, i_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL fetch_hold: got iv=%b id=%h expected 0 deadbeef", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_store();
        cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
        d_be = 4'h3; #1;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_err++; $display("FAIL store_gnt: got %b expected 01", {i_gnt, d_gnt});
        end
        cyc(); d_req = 1'b0; d_we = 1'b0; m_ack = 1'b1; m_rdata = 32'hAAAA5555; #1;
        n_cmp++;
        if ({m_req, m_we, m_be, m_addr, m_wdata} !==
            {1'b1, 1'b1, 4'h3, 32'h200, 32'h12345678}) begin
            n_err++;
            $display("FAIL store_bus: got req=%b we=%b be=%h addr=%h wd=%h expected 1 1 3 200 12345678",
                     m_req, m_we, m_be, m_addr, m_wdata);
        end
        cyc(); m_ack = 1'b0; #1;
        n_cmp++;
        if ({d_rvalid, d_rdata, i_rvalid} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL store_resp: got dv=%b dd=%h iv=%b expected 1 0 0",
                     d_rvalid, d_rdata, i_rvalid);
        end
        cyc(); #1;
        n_cmp++;
        if (d_rvalid !== 1'b0) begin
            n_err++; $display("FAIL store_pulse: got dv=%b expected 0", d_rvalid);
        end
    endtask

    task automatic test_simultaneous();
        cyc(); i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h400; d_be = 4'hF; #1;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_err++; $display("FAIL simul_gnt: got %b expected 01", {i_gnt, d_gnt});
        end
        cyc(); d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h11112222; #1;
        n_cmp++;
        if ({i_gnt, m_addr, m_we} !== {1'b0, 32'h400, 1'b0}) begin
            n_err++;
            $display("FAIL simul_busy: got ig=%b addr=%h we=%b expected 0 400 0",
                     i_gnt, m_addr, m_we);
        end
        cyc(); m_ack = 1'b0; #1;
        n_cmp++;
        if ({d_rvalid, d_rdata, i_gnt} !== {1'b1, 32'h11112222, 1'b1}) begin
            n_err++;
            $display("FAIL simul_load_then_fetch: got dv=%b dd=%h ig=%b expected 1 11112222 1",
                     d_rvalid, d_rdata, i_gnt);
        end
        cyc(); i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h33334444; #1;
        n_cmp++;
        if ({m_addr, m_be, m_we} !== {32'h300, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL simul_fetch_bus: got addr=%h be=%h we=%b expected 300 f 0",
                     m_addr, m_be, m_we);
        end
        cyc(); m_ack = 1'b0; #1;
        n_cmp++;
        if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h33334444, 1'b0}) begin
            n_err++;
            $display("FAIL simul_fetch_resp: got iv=%b id=%h dv=%b expected 1 33334444 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic [1:0] exp_gnt;
        for (int k = 0; k < 10; k++) begin
            cyc(); m_ack = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; #1;
            // Four data grants, then fetch breaks the streak.
            exp_gnt = (k % 5 == 4) ? 2'b10 : 2'b01;
            n_cmp++;
            if ({i_gnt, d_gnt} !== exp_gnt) begin
                n_err++;
                $display("FAIL starve_grant_%0d: got %b expected %b", k, {i_gnt, d_gnt}, exp_gnt);
            end
            cyc(); m_ack = 1'b1; m_rdata = 32'h5000 + k; #1;
        end
        cyc(); m_ack = 1'b0; i_req = 1'b0; d_req = 1'b0; #1;
    endtask

    task automatic test_reset_mid();
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; #1;
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL rmid_gnt: got %b expected 1", d_gnt);
        end
        cyc(); d_req = 1'b0; #1;
        n_cmp++;
        if (m_req !== 1'b1) begin
            n_err++; $display("FAIL rmid_busy: got m_req=%b expected 1", m_req);
        end
        #3; rst = 1'b1; #1;
        n_cmp++;
        if ({m_req, d_rvalid, d_rdata, i_rdata} !== 66'h0) begin
            n_err++;
            $display("FAIL rmid_async: got mreq=%b dv=%b dd=%h id=%h expected 0 0 0 0",
                     m_req, d_rvalid, d_rdata, i_rdata);
        end
        cyc(); rst = 1'b0;
        cyc(); m_ack = 1'b1; m_rdata = 32'hBADBAD00; #1;
        cyc(); m_ack = 1'b0; i_req = 1'b1; i_addr = 32'h600; #1;
        n_cmp++;
        if ({d_rvalid, i_rvalid, m_req, i_gnt} !== 4'b0001) begin
            n_err++;
            $display("FAIL rmid_late_ack: got dv=%b iv=%b mreq=%b ig=%b expected 0 0 0 1",
                     d_rvalid, i_rvalid, m_req, i_gnt);
        end
        cyc(); i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hCAFEF00D; #1;
        n_cmp++;
        if ({m_req, m_addr} !== {1'b1, 32'h600}) begin
            n_err++;
            $display("FAIL rmid_fetch_bus: got req=%b addr=%h expected 1 600", m_req, m_addr);
        end
        cyc(); m_ack = 1'b0; #1;
        n_cmp++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_err++;
            $display("FAIL rmid_fetch_resp: got iv=%b id=%h expected 1 cafef00d", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_spurious_ack();
        cyc(); m_ack = 1'b1; m_rdata = 32'hFFFFFFFF; #1;
        cyc(); m_ack = 1'b0; #1;
        n_cmp++;
        if ({i_rvalid, d_rvalid, m_req, i_rdata, d_rdata} !=
            {1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0}) begin
            n_err++;
            $display("FAIL spur_noresp: got iv=%b dv=%b mreq=%b id=%h dd=%h expected 0 0 0 cafef00d 0",
                     i_rvalid, d_rvalid, m_req, i_rdata, d_rdata);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; #1;
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL spur_still_idle: got d_gnt=%b expected 1", d_gnt);
        end
        cyc(); d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0BADCAFE; #1;
        cyc(); m_ack = 1'b0; #1;
        n_cmp++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h0BADCAFE}) begin
            n_err++;
            $display("FAIL spur_after_load: got dv=%b dd=%h expected 1 0badcafe", d_rvalid, d_rdata);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_spurious_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the CPU instruction-fetch port and its load/store port.
- Sits between the CPU core and the unified instruction/data memory.
- Data accesses have priority, so an in-flight load/store never deadlocks the pipeline.
- A streak counter bounds fetch starvation.
- Non-pipelined: one outstanding memory transaction at a time; memory latency is variable (ack-driven).

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; must be a multiple of 8
MAX_STREAK, 4, max consecutive data grants while fetch is waiting; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_req  in  1  fetch request; held until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch data valid, 1-cycle pulse
i_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = write
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_be  in  DATA_W/8  byte enables (writes)
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data / store completion, 1-cycle pulse
d_rdata  out  DATA_W  load data; 0 for stores
m_req  out  1  memory request; held until m_ack
m_we  out  1  memory write
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  DATA_W/8  memory byte enables; all-ones for fetch
m_ack  in  1  memory done, 1-cycle pulse; m_rdata valid with it
m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, active-high): state IDLE, streak = 0. All outputs 0: gnt, rvalid, rdata, m_* registers.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: fetch transaction outstanding.
  - BUSY_D: data transaction outstanding.
- Grant (combinational, IDLE only):
  - d_req & !(i_req & streak == MAX_STREAK) -> d_gnt.
  - Otherwise i_req -> i_gnt.
  - At most one gnt per cycle. gnt is never asserted outside IDLE.
- On a grant edge:
  - Capture the request into the m_* registers.
  - m_req = 1 from the next cycle; next state BUSY_I or BUSY_D.
  - Fetch sets m_we = 0 and m_be = all-ones.
- Streak counter:
  - d grant with i_req high: streak + 1, saturating at MAX_STREAK.
  - d grant with i_req low: streak = 0.
  - i grant: streak = 0.
- BUSY_x:
  - m_req and m_* held stable until m_ack.
  - On m_ack: m_req = 0, state = IDLE.
  - Owner's rvalid = 1 and rdata = m_rdata (d_rdata = 0 for writes), both registered and visible the cycle after m_ack.
  - Non-owner rvalid stays 0.
  - rvalid deasserts after one cycle; rdata holds its value until the next rvalid.
- Latency: grant at cycle 0, m_req from cycle 1, m_ack at cycle k >= 1, rvalid at k+1.
  - A new grant is possible at k+1, so there is one idle bus cycle minimum between transactions.
- m_ack in IDLE: ignored, no rvalid.
- Requesters may drop req before gnt; the arbiter then grants nothing and the request is lost.
- Reset mid-transaction: m_req drops immediately and the transaction is abandoned. No rvalid is produced. The memory must tolerate the abandoned request.
- Requester req/addr changes during BUSY do not affect m_* outputs.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, BUSY_I, BUSY_D)
  - owner enum (OWN_I, OWN_D)
  - default ADDR_W/DATA_W constants
- Sub-module mem_arb_select: grant decision plus the saturating streak counter.
  - Inputs: clk, rst, idle, i_req, d_req.
  - Outputs: i_gnt, d_gnt.
- The top level holds the FSM, request registers and response registers.

Test Plan:
- Single fetch:
  - Stimulus: i_req, i_addr = 0x100; memory acks 2 cycles after m_req with 0xDEADBEEF.
  - Response: i_gnt at cycle 0; m_req cycles 1–2 with m_addr = 0x100, m_we = 0, m_be = 0xF; i_rvalid at cycle 3 with i_rdata = 0xDEADBEEF; d_rvalid = 0.
- Store:
  - Stimulus: d_req, d_we = 1, d_addr = 0x200, d_wdata = 0x12345678, d_be = 0x3; 1-cycle ack.
  - Response: m_we = 1, m_be = 0x3, m_wdata = 0x12345678; d_rvalid one pulse with d_rdata = 0.
- Simultaneous requests in IDLE:
  - Response: d_gnt, no i_gnt; fetch is granted in the IDLE cycle after the data transaction completes.
- Starvation, MAX_STREAK = 4:
  - Stimulus: d_req and i_req both held high continuously.
  - Response: grant order D, D, D, D, I, D, D, D, D, I…
- Reset mid-transaction:
  - Stimulus: assert rst while BUSY_D with m_req high.
  - Response: m_req = 0 asynchronously; no d_rvalid; a late m_ack after reset release is ignored; the next i_req is granted normally.
- Spurious m_ack in IDLE:
  - Response: no rvalid on either port and state remains IDLE.
